// File: rtl/rvga_ddr_arbiter_pkg.sv
// ============================================================================
// Module      : rvga_ddr_arbiter_pkg
// Description : Shared types and constants for the L1-to-DDR arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvga_ddr_arbiter_pkg;

    // Arbiter transaction FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } rvga_arb_state_e;

    // Arbitration policy selectors
    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // Width of a client index; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rvga_ddr_arbiter_if.sv
// ============================================================================
// Module      : rvga_ddr_arbiter_if
// Description : Bundle of the L1-client and DDR-port signals of the arbiter.
//               master = arbiter view, slave = clients + DDR controller view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rvga_ddr_arbiter_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256
);

    // L1 client side
    logic [NUM_CLIENTS*ADDR_W-1:0] l1_arb_addr;
    logic [NUM_CLIENTS-1:0]        l1_arb_read;
    logic [NUM_CLIENTS-1:0]        l1_arb_write;
    logic [NUM_CLIENTS*LINE_W-1:0] l1_arb_wdata;
    logic [LINE_W-1:0]             arb_l1_rdata;
    logic [NUM_CLIENTS-1:0]        arb_l1_resp;

    // DDR controller side
    logic [ADDR_W-1:0]             arb_ddr_addr;
    logic                          arb_ddr_read;
    logic                          arb_ddr_write;
    logic [LINE_W-1:0]             arb_ddr_wdata;
    logic [LINE_W-1:0]             ddr_arb_rdata;
    logic                          ddr_arb_resp;

    modport master (
        input  l1_arb_addr, l1_arb_read, l1_arb_write, l1_arb_wdata,
        input  ddr_arb_rdata, ddr_arb_resp,
        output arb_l1_rdata, arb_l1_resp,
        output arb_ddr_addr, arb_ddr_read, arb_ddr_write, arb_ddr_wdata
    );

    modport slave (
        output l1_arb_addr, l1_arb_read, l1_arb_write, l1_arb_wdata,
        output ddr_arb_rdata, ddr_arb_resp,
        input  arb_l1_rdata, arb_l1_resp,
        input  arb_ddr_addr, arb_ddr_read, arb_ddr_write, arb_ddr_wdata
    );

endinterface

`default_nettype wire

// File: rtl/rvga_ddr_arbiter_rr_picker.sv
// ============================================================================
// Module      : rvga_ddr_arbiter_rr_picker
// Description : Combinational winner picker. MODE 0 searches upward from the
//               round-robin pointer with wrap; MODE 1 picks the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvga_ddr_arbiter_rr_picker
    import rvga_ddr_arbiter_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = ARB_MODE_RR,
    parameter int IW   = idx_width(N)
) (
    input  wire logic [N-1:0]  req_i,
    input  wire logic [IW-1:0] ptr_i,
    output logic      [N-1:0]  gnt_o,
    output logic               valid_o
);

    localparam int IW1 = IW + 1;

    if (MODE == ARB_MODE_FIXED) begin : g_fixed
        logic found;
        logic w_unused_ptr;

        // Pointer has no meaning for fixed priority
        assign w_unused_ptr = ^ptr_i;

        // Lowest requesting index wins
        always_comb begin
            gnt_o = '0;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_i[k]) begin
                    gnt_o[k] = 1'b1;
                    found    = 1'b1;
                end
            end
            valid_o = found;
        end
    end else begin : g_rr
        logic           found;
        logic [IW1-1:0] sum;
        logic [IW-1:0]  idx;

        // First requester at or after the pointer, wrapping past N-1
        always_comb begin
            gnt_o = '0;
            found = 1'b0;
            sum   = '0;
            idx   = '0;
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, ptr_i} + IW1'(k);
                if (sum >= IW1'(N)) begin
                    sum = sum - IW1'(N);
                end
                idx = sum[IW-1:0];
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
            valid_o = found;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rvga_ddr_arbiter.sv
// ============================================================================
// Module      : rvga_ddr_arbiter
// Description : Merges N per-cache DDR channels onto one DDR port, one whole
//               cacheline transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvga_ddr_arbiter
    import rvga_ddr_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int ARB_MODE    = ARB_MODE_RR
) (
    input wire logic           clk,
    input wire logic           rst,
    rvga_ddr_arbiter_if.master bus
);

    localparam int IW = idx_width(NUM_CLIENTS);

    rvga_arb_state_e          state_q, state_d;

    logic [NUM_CLIENTS-1:0]   req;
    logic [NUM_CLIENTS-1:0]   pick_gnt;
    logic                     pick_valid;

    logic [IW-1:0]            win_idx;
    logic [ADDR_W-1:0]        win_addr;
    logic [LINE_W-1:0]        win_wdata;
    logic                     win_write;

    logic [IW-1:0]            gnt_idx_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [LINE_W-1:0]        wdata_q;
    logic                     write_q;
    logic [LINE_W-1:0]        rdata_q;
    logic [IW-1:0]            ptr_q;

    logic                     latch_en;
    logic                     capture_en;
    logic                     ddr_read;
    logic                     ddr_write;
    logic [NUM_CLIENTS-1:0]   l1_resp;

    assign req = bus.l1_arb_read | bus.l1_arb_write;

    rvga_ddr_arbiter_rr_picker #(
        .N    (NUM_CLIENTS),
        .MODE (ARB_MODE),
        .IW   (IW)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // Steer the one-hot winner's index, address, op and line; write wins on read+write
    always_comb begin
        win_idx   = '0;
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (pick_gnt[i]) begin
                win_idx   = IW'(i);
                win_addr  = bus.l1_arb_addr[i*ADDR_W +: ADDR_W];
                win_wdata = bus.l1_arb_wdata[i*LINE_W +: LINE_W];
                win_write = bus.l1_arb_write[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs; DDR responses outside GRANT are ignored
    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        ddr_read   = 1'b0;
        ddr_write  = 1'b0;
        l1_resp    = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    latch_en = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                ddr_read  = ~write_q;
                ddr_write = write_q;
                if (bus.ddr_arb_resp) begin
                    capture_en = ~write_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                l1_resp[gnt_idx_q] = 1'b1;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction registers, read-line capture and round-robin pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            ptr_q     <= '0;
        end else begin
            if (latch_en) begin
                gnt_idx_q <= win_idx;
                addr_q    <= win_addr;
                wdata_q   <= win_wdata;
                write_q   <= win_write;
            end
            if (capture_en) begin
                rdata_q <= bus.ddr_arb_rdata;
            end
            if (state_q == DONE) begin
                ptr_q <= (gnt_idx_q == IW'(NUM_CLIENTS - 1)) ? '0 : gnt_idx_q + IW'(1);
            end
        end
    end

    // Flag a client asserting read and write together while it can be sampled
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE) begin
            assert ((bus.l1_arb_read & bus.l1_arb_write) == '0);
        end
    end

    assign bus.arb_l1_rdata  = rdata_q;
    assign bus.arb_l1_resp   = l1_resp;
    assign bus.arb_ddr_addr  = addr_q;
    assign bus.arb_ddr_wdata = wdata_q;
    assign bus.arb_ddr_read  = ddr_read;
    assign bus.arb_ddr_write = ddr_write;

endmodule

`default_nettype wire

// File: tb/tb_rvga_ddr_arbiter.sv
// ============================================================================
// Module      : tb_rvga_ddr_arbiter
// Description : Self-checking bench; one round-robin and one fixed-priority
//               arbiter, each with its own DDR responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvga_ddr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    int lat_a = 3;
    int lat_b = 2;
    int stray_req_a = 0;

    logic [AW-1:0] wr_addr_a = '0;
    logic [LW-1:0] wr_data_a = '0;
    int            wr_cnt_a  = 0;

    always #5 clk = ~clk;

    rvga_ddr_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW)) ifA ();
    rvga_ddr_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW)) ifB ();

    rvga_ddr_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    rvga_ddr_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(1)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    // Content the DDR memory returns for a line address
    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        if (a == 32'h0000_1000) return {32{8'hA5}};
        return {8{a ^ 32'h9E37_79B9}};
    endfunction

    // DDR responder for the round-robin arbiter: resp lat_a cycles after the op rises
    initial begin : ddr_model_a
        int cnt;
        int stray_seen;
        cnt = 0;
        stray_seen = 0;
        ifA.ddr_arb_resp  = 1'b0;
        ifA.ddr_arb_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
                ifA.ddr_arb_resp = 1'b0;
            end else if (ifA.ddr_arb_resp) begin
                ifA.ddr_arb_resp = 1'b0;
            end else if (stray_req_a != stray_seen) begin
                stray_seen = stray_req_a;
                ifA.ddr_arb_resp  = 1'b1;
                ifA.ddr_arb_rdata = {LW{1'b1}};
            end else if (ifA.arb_ddr_read || ifA.arb_ddr_write) begin
                cnt++;
                if (cnt >= lat_a) begin
                    cnt = 0;
                    ifA.ddr_arb_resp  = 1'b1;
                    ifA.ddr_arb_rdata = line_for(ifA.arb_ddr_addr);
                    if (ifA.arb_ddr_write) begin
                        wr_addr_a = ifA.arb_ddr_addr;
                        wr_data_a = ifA.arb_ddr_wdata;
                        wr_cnt_a++;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // DDR responder for the fixed-priority arbiter
    initial begin : ddr_model_b
        int cnt;
        cnt = 0;
        ifB.ddr_arb_resp  = 1'b0;
        ifB.ddr_arb_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
                ifB.ddr_arb_resp = 1'b0;
            end else if (ifB.ddr_arb_resp) begin
                ifB.ddr_arb_resp = 1'b0;
            end else if (ifB.arb_ddr_read || ifB.arb_ddr_write) begin
                cnt++;
                if (cnt >= lat_b) begin
                    cnt = 0;
                    ifB.ddr_arb_resp  = 1'b1;
                    ifB.ddr_arb_rdata = line_for(ifB.arb_ddr_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ifA.arb_l1_resp, ifA.arb_ddr_read, ifA.arb_ddr_write, ifA.arb_ddr_addr,
             ifA.arb_ddr_wdata, ifA.arb_l1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_rr: got resp=%b rd=%b wr=%b addr=%h rdata=%h, expected all 0",
                     ifA.arb_l1_resp, ifA.arb_ddr_read, ifA.arb_ddr_write, ifA.arb_ddr_addr, ifA.arb_l1_rdata);
        end
        n_checks++;
        if ({ifB.arb_l1_resp, ifB.arb_ddr_read, ifB.arb_ddr_write, ifB.arb_ddr_addr,
             ifB.arb_ddr_wdata, ifB.arb_l1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_fp: got resp=%b rd=%b wr=%b addr=%h, expected all 0",
                     ifB.arb_l1_resp, ifB.arb_ddr_read, ifB.arb_ddr_write, ifB.arb_ddr_addr);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ifA.arb_l1_resp, ifB.arb_l1_resp, ifA.arb_ddr_read, ifB.arb_ddr_read} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle_quiet c%0d: got respA=%b respB=%b rdA=%b rdB=%b, expected 0",
                         c, ifA.arb_l1_resp, ifB.arb_l1_resp, ifA.arb_ddr_read, ifB.arb_ddr_read);
            end
        end
    endtask

    task automatic test_single_read();
        logic [N-1:0] exp_resp;
        lat_a = 3;
        ifA.l1_arb_addr[AW +: AW] = 32'h0000_1000;
        ifA.l1_arb_read = 2'b10;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_resp = (c == 4) ? 2'b10 : 2'b00;
            n_checks++;
            if (ifA.arb_ddr_read !== (c <= 3) || ifA.arb_ddr_write !== 1'b0) begin
                n_fail++;
                $display("FAIL single_read_ddr_op c%0d: got rd=%b wr=%b, expected rd=%b wr=0",
                         c, ifA.arb_ddr_read, ifA.arb_ddr_write, (c <= 3));
            end
            n_checks++;
            if (ifA.arb_l1_resp !== exp_resp) begin
                n_fail++;
                $display("FAIL single_read_resp c%0d: got %b, expected %b", c, ifA.arb_l1_resp, exp_resp);
            end
            if (c <= 3) begin
                n_checks++;
                if (ifA.arb_ddr_addr !== 32'h0000_1000) begin
                    n_fail++;
                    $display("FAIL single_read_addr c%0d: got %h, expected 00001000", c, ifA.arb_ddr_addr);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (ifA.arb_l1_rdata !== {32{8'hA5}}) begin
                    n_fail++;
                    $display("FAIL single_read_rdata: got %h, expected a5 repeated", ifA.arb_l1_rdata);
                end
                ifA.l1_arb_read = 2'b00;
            end
        end
    endtask

    task automatic test_write();
        int wcnt0;
        logic [N-1:0] exp_resp;
        lat_a = 2;
        wcnt0 = wr_cnt_a;
        ifA.l1_arb_addr[AW +: AW]  = 32'h0000_2000;
        ifA.l1_arb_wdata[LW +: LW] = {8{32'hDEAD_BEEF}};
        ifA.l1_arb_write = 2'b10;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp_resp = (c == 3) ? 2'b10 : 2'b00;
            n_checks++;
            if (ifA.arb_ddr_write !== (c <= 2) || ifA.arb_ddr_read !== 1'b0) begin
                n_fail++;
                $display("FAIL write_ddr_op c%0d: got wr=%b rd=%b, expected wr=%b rd=0",
                         c, ifA.arb_ddr_write, ifA.arb_ddr_read, (c <= 2));
            end
            n_checks++;
            if (ifA.arb_l1_resp !== exp_resp) begin
                n_fail++;
                $display("FAIL write_resp c%0d: got %b, expected %b", c, ifA.arb_l1_resp, exp_resp);
            end
            n_checks++;
            if (ifA.arb_l1_rdata !== {32{8'hA5}}) begin
                n_fail++;
                $display("FAIL write_rdata_kept c%0d: got %h, expected a5 repeated", c, ifA.arb_l1_rdata);
            end
            if (c == 1) begin
                n_checks++;
                if (ifA.arb_ddr_addr !== 32'h0000_2000 || ifA.arb_ddr_wdata !== {8{32'hDEAD_BEEF}}) begin
                    n_fail++;
                    $display("FAIL write_addr_data: got addr=%h wdata=%h, expected 00002000 / deadbeef repeated",
                             ifA.arb_ddr_addr, ifA.arb_ddr_wdata);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (wr_cnt_a !== wcnt0 + 1 || wr_addr_a !== 32'h0000_2000 || wr_data_a !== {8{32'hDEAD_BEEF}}) begin
                    n_fail++;
                    $display("FAIL write_ddr_seen: got count=%0d addr=%h, expected count=%0d addr=00002000",
                             wr_cnt_a, wr_addr_a, wcnt0 + 1);
                end
                ifA.l1_arb_write = 2'b00;
            end
        end
    endtask

    task automatic test_rr_fairness();
        logic [N-1:0] exp_oh;
        logic [AW-1:0] exp_addr;
        logic got;
        lat_a = 2;
        ifA.l1_arb_addr = {32'h0000_0200, 32'h0000_0100};
        ifA.l1_arb_read = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_oh   = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (ifA.arb_l1_resp !== 2'b00) got = 1'b1;
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL rr_timeout t%0d: got no resp in 20 cycles, expected %b", t, exp_oh);
            end else if (ifA.arb_l1_resp !== exp_oh || ifA.arb_l1_rdata !== line_for(exp_addr)) begin
                n_fail++;
                $display("FAIL rr_order t%0d: got resp=%b rdata=%h, expected resp=%b rdata=%h",
                         t, ifA.arb_l1_resp, ifA.arb_l1_rdata, exp_oh, line_for(exp_addr));
            end
        end
        ifA.l1_arb_read = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        logic got;
        logic [N-1:0] exp_oh;
        lat_b = 2;
        ifB.l1_arb_addr = {32'h0000_0500, 32'h0000_0400};
        ifB.l1_arb_read = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_oh = (t < 3) ? 2'b01 : 2'b10;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (ifB.arb_l1_resp !== 2'b00) got = 1'b1;
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL fp_timeout t%0d: got no resp in 20 cycles, expected %b", t, exp_oh);
            end else if (ifB.arb_l1_resp !== exp_oh ||
                         ifB.arb_l1_rdata !== line_for((t < 3) ? 32'h0000_0400 : 32'h0000_0500)) begin
                n_fail++;
                $display("FAIL fp_order t%0d: got resp=%b rdata=%h, expected resp=%b",
                         t, ifB.arb_l1_resp, ifB.arb_l1_rdata, exp_oh);
            end
            if (t == 2) ifB.l1_arb_read = 2'b10;
            if (t == 3) ifB.l1_arb_read = 2'b00;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic got;
        lat_a = 50;
        ifA.l1_arb_addr[0 +: AW] = 32'h0000_0300;
        ifA.l1_arb_read = 2'b01;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ifA.arb_ddr_read !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_grant: got rd=%b, expected 1", ifA.arb_ddr_read);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ifA.arb_ddr_read, ifA.arb_ddr_write, ifA.arb_l1_resp, ifA.arb_ddr_addr, ifA.arb_l1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs: got rd=%b wr=%b resp=%b addr=%h, expected all 0",
                     ifA.arb_ddr_read, ifA.arb_ddr_write, ifA.arb_l1_resp, ifA.arb_ddr_addr);
        end
        rst = 1'b0;
        lat_a = 2;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ifA.arb_l1_resp !== 2'b00) got = 1'b1;
        end
        n_checks++;
        if (!got || ifA.arb_l1_resp !== 2'b01 || ifA.arb_l1_rdata !== line_for(32'h0000_0300)) begin
            n_fail++;
            $display("FAIL midop_reissue: got seen=%b resp=%b rdata=%h, expected resp=01 rdata=%h",
                     got, ifA.arb_l1_resp, ifA.arb_l1_rdata, line_for(32'h0000_0300));
        end
        ifA.l1_arb_read = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_stray_resp();
        stray_req_a++;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ifA.arb_l1_resp, ifA.arb_ddr_read, ifA.arb_ddr_write} !== '0 ||
                ifA.arb_l1_rdata !== line_for(32'h0000_0300)) begin
                n_fail++;
                $display("FAIL stray_resp c%0d: got resp=%b rd=%b wr=%b rdata=%h, expected quiet, rdata=%h",
                         c, ifA.arb_l1_resp, ifA.arb_ddr_read, ifA.arb_ddr_write, ifA.arb_l1_rdata,
                         line_for(32'h0000_0300));
            end
        end
    endtask

    // Random clients against a transaction-level round-robin reference
    task automatic test_random();
        logic [N-1:0]  req, req_prev, exp_oh;
        logic [AW-1:0] a  [N];
        logic          wr [N];
        logic [LW-1:0] wd [N];
        logic [LW-1:0] exp_rdata;
        logic          op_now, op_prev, in_flight;
        int ptr_m, exp_win, win, idx, done;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req = '0; req_prev = '0; op_prev = 1'b0; in_flight = 1'b0;
        exp_rdata = '0; ptr_m = 0; exp_win = 0; done = 0;
        for (int i = 0; i < N; i++) begin
            a[i] = '0; wr[i] = 1'b0; wd[i] = '0;
        end
        ifA.l1_arb_read = '0;
        ifA.l1_arb_write = '0;

        for (int cyc = 0; cyc < 4000 && done < 40; cyc++) begin
            @(negedge clk);
            op_now = ifA.arb_ddr_read | ifA.arb_ddr_write;
            if (op_now && !op_prev) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (ptr_m + k) % N;
                    if (win < 0 && req_prev[idx]) win = idx;
                end
                n_checks++;
                if (win < 0 || in_flight) begin
                    n_fail++;
                    $display("FAIL rand_grant: got ddr op with reqs=%b in_flight=%b, expected no op",
                             req_prev, in_flight);
                end else if (ifA.arb_ddr_addr !== a[win] || ifA.arb_ddr_write !== wr[win] ||
                             ifA.arb_ddr_read !== !wr[win] ||
                             (wr[win] && ifA.arb_ddr_wdata !== wd[win])) begin
                    n_fail++;
                    $display("FAIL rand_grant_fields: got addr=%h wr=%b, expected client %0d addr=%h wr=%b",
                             ifA.arb_ddr_addr, ifA.arb_ddr_write, win, a[win], wr[win]);
                end
                if (win >= 0) begin
                    exp_win = win;
                    in_flight = 1'b1;
                end
                lat_a = $urandom_range(1, 5);
            end
            if (ifA.arb_l1_resp !== '0) begin
                exp_oh = '0;
                exp_oh[exp_win] = 1'b1;
                n_checks++;
                if (!in_flight || ifA.arb_l1_resp !== exp_oh) begin
                    n_fail++;
                    $display("FAIL rand_resp: got %b, expected %b (in_flight=%b)", ifA.arb_l1_resp, exp_oh, in_flight);
                end else begin
                    if (!wr[exp_win]) begin
                        exp_rdata = line_for(a[exp_win]);
                    end else begin
                        n_checks++;
                        if (wr_addr_a !== a[exp_win] || wr_data_a !== wd[exp_win]) begin
                            n_fail++;
                            $display("FAIL rand_write_data: got addr=%h, expected addr=%h", wr_addr_a, a[exp_win]);
                        end
                    end
                    ptr_m = (exp_win + 1) % N;
                    req[exp_win] = 1'b0;
                    done++;
                end
                in_flight = 1'b0;
            end
            n_checks++;
            if (ifA.arb_l1_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL rand_rdata cyc%0d: got %h, expected %h", cyc, ifA.arb_l1_rdata, exp_rdata);
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    wr[i]  = $urandom_range(0, 1) == 1;
                    a[i]   = $urandom & 32'hFFFF_FFE0;
                    for (int j = 0; j < LW / 32; j++) wd[i][j*32 +: 32] = $urandom;
                end
                ifA.l1_arb_addr[i*AW +: AW]  = a[i];
                ifA.l1_arb_wdata[i*LW +: LW] = wd[i];
                ifA.l1_arb_read[i]  = req[i] & ~wr[i];
                ifA.l1_arb_write[i] = req[i] & wr[i];
            end
            req_prev = req;
            op_prev  = op_now;
        end
        n_checks++;
        if (done < 40) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d completions, expected 40", done);
        end
        ifA.l1_arb_read  = '0;
        ifA.l1_arb_write = '0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        ifA.l1_arb_addr = '0; ifA.l1_arb_read = '0; ifA.l1_arb_write = '0; ifA.l1_arb_wdata = '0;
        ifB.l1_arb_addr = '0; ifB.l1_arb_read = '0; ifB.l1_arb_write = '0; ifB.l1_arb_wdata = '0;
        test_reset();
        test_single_read();
        test_write();
        test_rr_fairness();
        test_fixed_priority();
        test_reset_mid_op();
        test_stray_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
